// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed 7-segment scan driver.
//   NUM_DIGITS : number of multiplexed digits on the board
//   SEG_OFF    : all segments dark (active-low segment bus)
//   AN_OFF     : all digit enables off (active-low anode bus)
//   SEG_HEX    : 16-entry hex glyph table, active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    // Glyphs 0-9, A, b, C, d, E, F (lower-case b/d so they differ from 8/0).
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Pure combinational 4-bit to 7-segment lookup (active-low segments).
//   nibble : hex value to display
//   seg    : segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Scans an 8-digit common-anode 7-segment display, one digit per slot of
// SCAN_DIV clocks. The display word is copied into a shadow register only at
// frame boundaries (and once right after reset) so a frame never mixes values.
//
// Parameters
//   SCAN_DIV : clk cycles per digit slot (>= 2)
//   DIV_W    : prescaler width, 2**DIV_W >= SCAN_DIV
// Ports
//   clk         : system clock
//   rst         : synchronous active-high reset
//   disp_word   : nibble i shown on digit i (digit 0 rightmost)
//   dp_mask     : 1 = decimal point lit on digit i
//   an          : digit enables, active-low, at most one low
//   seg         : segments {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   frame_start : one-cycle pulse when the shadow word reloads at frame wrap
//
// Build option
//   SEG7_LZ_BLANK_EN : when defined, leading zeros (digits 1..7) are blanked.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_word,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    logic [DIV_W-1:0] presc_reg;
    logic [2:0]       idx_reg;
    logic [31:0]      shadow_reg;
    logic [7:0]       shadow_dp_reg;
    logic [7:0]       blank_reg;
    logic             first_reg;
    logic [7:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic             frame_start_reg;

    logic             tick;
    logic             wrap;
    logic             capture;
    logic [7:0]       blank_next;
    logic [3:0]       nib_arr [NUM_DIGITS];
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;

    assign tick    = (presc_reg == DIV_W'(SCAN_DIV - 1));
    assign wrap    = tick && (idx_reg == 3'd7);
    // first_reg covers the single capture right after reset release, so the
    // first frame shows the live word instead of the cleared shadow.
    assign capture = first_reg || wrap;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib_arr[gi] = shadow_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_nib = nib_arr[idx_reg];

`ifdef SEG7_LZ_BLANK_EN
    // Digit i is a leading zero when nibble i and everything above it is 0.
    // Digit 0 always shows, so an all-zero word still reads "0".
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_d0
                assign blank_next[gi] = 1'b0;
            end else begin : g_dn
                assign blank_next[gi] = ~|disp_word[31:4*gi];
            end
        end
    endgenerate
`else
    assign blank_next = '0;
`endif

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg       <= '0;
            idx_reg         <= '0;
            shadow_reg      <= '0;
            shadow_dp_reg   <= '0;
            blank_reg       <= '0;
            first_reg       <= 1'b1;
            an_reg          <= AN_OFF;
            seg_reg         <= SEG_OFF;
            dp_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                idx_reg <= idx_reg + 3'd1;
            end

            if (capture) begin
                shadow_reg    <= disp_word;
                shadow_dp_reg <= dp_mask;
                blank_reg     <= blank_next;
            end
            first_reg <= 1'b0;

            // Only true frame wraps pulse, keeping the pulse period uniform.
            frame_start_reg <= wrap;

            // Dark for the first cycle of every slot so the previous digit's
            // segments never flash on the newly enabled anode.
            an_reg  <= (presc_reg == '0) ? AN_OFF : ~(8'b1 << idx_reg);
            seg_reg <= blank_reg[idx_reg] ? SEG_OFF : dec_seg;
            dp_reg  <= ~shadow_dp_reg[idx_reg];
        end
    end

    assign an          = an_reg;
    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with SCAN_DIV=4. A cycle model
// pushes the expected outputs each clock; a monitor pops and compares them.
// Directed checks cover the glyph sequences, capture timing, dp, reset and
// frame period. Honours SEG7_LZ_BLANK_EN like the design.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int SD = 4;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp_word = 32'h0;
    logic [7:0]  dp_mask = 8'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [6:0] t1_seg [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [6:0] t2_seg [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG7_LZ_BLANK_EN
    logic [6:0] t5a_seg [8] = '{7'h40, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] t5b_seg [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
    logic [6:0] t5a_seg [8] = '{7'h40, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [6:0] t5b_seg [8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif

    seg7_scan_driver #(
        .SCAN_DIV (SD),
        .DIV_W    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_word   (disp_word),
        .dp_mask     (dp_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    exp_t        sb_q [$];
    exp_t        m_e;
    int          m_presc = 0;
    int          m_idx = 0;
    logic [31:0] m_sh = 0;
    logic [7:0]  m_shdp = 0;
    logic [7:0]  m_blank = 0;
    logic        m_first = 1;
    logic        m_wrap;
    logic [3:0]  m_nib;

    function automatic logic [7:0] lz_mask(input logic [31:0] w);
        logic [7:0] m;
        m = 8'h00;
`ifdef SEG7_LZ_BLANK_EN
        for (int i = 1; i < 8; i++) begin
            if ((w >> (4 * i)) == 32'h0) m[i] = 1'b1;
        end
`endif
        return m;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_e     = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
            m_presc = 0;
            m_idx   = 0;
            m_sh    = 0;
            m_shdp  = 0;
            m_blank = 0;
            m_first = 1;
        end else begin
            m_e.an  = (m_presc == 0) ? 8'hFF : ~(8'b1 << m_idx);
            m_nib   = m_sh[4*m_idx +: 4];
            m_e.seg = m_blank[m_idx] ? 7'h7F : hex_tab[m_nib];
            m_e.dp  = ~m_shdp[m_idx];
            m_wrap  = (m_presc == SD - 1) && (m_idx == 7);
            m_e.fs  = m_wrap;
            if (m_first || m_wrap) begin
                m_sh    = disp_word;
                m_shdp  = dp_mask;
                m_blank = lz_mask(disp_word);
            end
            m_first = 0;
            if (m_presc == SD - 1) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % 8;
            end else begin
                m_presc++;
            end
        end
        sb_q.push_back(m_e);
    end

    // ---------------- monitor ----------------
    exp_t got_e;
    int   cyc = 0;
    int   last_fs = -1;
    int   n_periods = 0;

    always @(negedge clk) begin
        cyc++;
        if (sb_q.size() > 0) begin
            got_e = sb_q.pop_front();
            chk("out", {an, seg, dp, frame_start}, got_e);
            chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        end
        if (rst) begin
            last_fs = -1;
        end else if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
                chk("fs_period", cyc - last_fs, 8 * SD);
                n_periods++;
            end
            last_fs = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_lit(input int d);
        logic [7:0] want;
        bit found;
        want  = ~(8'b1 << d);
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            step();
            if (an == want) found = 1;
        end
        if (!found) chk("timeout_lit", an, want);
    endtask

    task automatic wait_fs();
        bit found;
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            step();
            if (frame_start == 1'b1) found = 1;
        end
        if (!found) chk("timeout_fs", frame_start, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst       = 1'b1;
        disp_word = 32'h76543210;
        dp_mask   = 8'h00;
        repeat (3) step();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_fs", frame_start, 0);
        rst = 1'b0;

        // 1: first frame after release shows the word captured at release
        for (int d = 0; d < 8; d++) begin
            wait_lit(d);
            chk("t1_seg", seg, t1_seg[d]);
        end

        // 2: mid-frame change is deferred to the next wrap
        wait_lit(3);
        disp_word = 32'hFEDCBA98;
        for (int d = 4; d < 8; d++) begin
            wait_lit(d);
            chk("t2_old_seg", seg, t1_seg[d]);
        end
        wait_fs();
        for (int d = 0; d < 8; d++) begin
            wait_lit(d);
            chk("t2_new_seg", seg, t2_seg[d]);
        end

        // 3: decimal points follow dp_mask from the next frame
        wait_lit(1);
        dp_mask = 8'h05;
        wait_lit(2);
        chk("t3_dp_old", dp, 1);
        wait_fs();
        for (int d = 0; d < 8; d++) begin
            wait_lit(d);
            chk("t3_dp", dp, (d == 0 || d == 2) ? 1'b0 : 1'b1);
        end

        // 4: reset mid-slot 5 blanks next cycle, then restart at digit 0
        wait_lit(5);
        step();
        rst = 1'b1;
        step();
        chk("t4_an", an, 8'hFF);
        chk("t4_seg", seg, 7'h7F);
        chk("t4_dp", dp, 1);
        step();
        rst = 1'b0;
        wait_lit(0);
        chk("t4_d0_seg", seg, 7'h00);
        wait_lit(1);
        chk("t4_d1_seg", seg, 7'h10);

        // 5: leading-zero handling
        disp_word = 32'h00000120;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int d = 0; d < 8; d++) begin
            wait_lit(d);
            chk("t5a_seg", seg, t5a_seg[d]);
        end
        disp_word = 32'h00000000;
        wait_fs();
        for (int d = 0; d < 8; d++) begin
            wait_lit(d);
            chk("t5b_seg", seg, t5b_seg[d]);
            if (d == 2) chk("t5b_dp2", dp, 0);
        end

        // 6: frame period keeps being checked by the monitor
        repeat (100) step();
        chk("t6_periods_seen", 32'(n_periods >= 3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
